// File: rtl/alu_sequencer.sv
// Control sequencer in front of alu_registers: decodes 16-bit instruction words
// into one-cycle register-file ops and waits out write-back / read latency.
package constants_pkg;
  typedef enum logic [1:0] {REG_READ = 2'd0, REG_WRITE = 2'd1, ADD = 2'd2, SUB = 2'd3} ALUOp;
endpackage

module alu_sequencer
  import constants_pkg::*;
#(
  parameter int ADDR_BITS    = 3,
  parameter int DATA_BITS    = 8,
  parameter int WB_CYCLES    = 2,
  parameter int READ_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [15:0]          instr,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  output ALUOp                 op,
  output logic [ADDR_BITS-1:0] addr_a,
  output logic [ADDR_BITS-1:0] addr_b,
  output logic [ADDR_BITS-1:0] addr_r,
  output logic [DATA_BITS-1:0] data_in,
  input  logic [DATA_BITS-1:0] data_out,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 rd_valid,
  output logic                 illegal,
  output logic                 busy
);

  localparam int CNT_MAX = (WB_CYCLES > READ_LATENCY) ? WB_CYCLES : READ_LATENCY;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [3:0] OPC_NOP   = 4'h0;
  localparam logic [3:0] OPC_LOADI = 4'h1;
  localparam logic [3:0] OPC_ADD   = 4'h2;
  localparam logic [3:0] OPC_SUB   = 4'h3;
  localparam logic [3:0] OPC_READ  = 4'h4;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t               state_q, state_d;
  logic [3:0]           opc_q, opc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  ALUOp                 op_q, op_d;
  logic [ADDR_BITS-1:0] addr_a_q, addr_a_d, addr_b_q, addr_b_d, addr_r_q, addr_r_d;
  logic [DATA_BITS-1:0] data_in_q, data_in_d, rd_data_q, rd_data_d;
  logic                 rd_valid_q, rd_valid_d, illegal_q, illegal_d;

  // Address fields only use their low bits; the rest of the word is don't-care.
  logic unused_instr;
  assign unused_instr = ^instr;

  always_comb begin
    state_d    = state_q;
    opc_d      = opc_q;
    cnt_d      = cnt_q;
    op_d       = REG_READ;
    addr_a_d   = '0;
    addr_b_d   = '0;
    addr_r_d   = addr_r_q;
    data_in_d  = '0;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    illegal_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          state_d = S_ISSUE;
          opc_d   = instr[15:12];
          case (instr[15:12])
            OPC_NOP: ;
            OPC_LOADI: begin
              op_d      = REG_WRITE;
              addr_a_d  = instr[8 +: ADDR_BITS];
              data_in_d = instr[DATA_BITS-1:0];
            end
            OPC_ADD, OPC_SUB: begin
              op_d     = (instr[15:12] == OPC_ADD) ? ADD : SUB;
              addr_a_d = instr[4 +: ADDR_BITS];
              addr_b_d = instr[0 +: ADDR_BITS];
              addr_r_d = instr[8 +: ADDR_BITS];
            end
            OPC_READ: addr_a_d = instr[8 +: ADDR_BITS];
            default:  illegal_d = 1'b1;
          endcase
        end
      end
      S_ISSUE: begin
        case (opc_q)
          OPC_ADD, OPC_SUB: begin
            state_d = S_WAIT;
            cnt_d   = CW'(WB_CYCLES);
          end
          OPC_READ: begin
            state_d = S_WAIT;
            cnt_d   = CW'(READ_LATENCY);
          end
          default: state_d = S_IDLE;
        endcase
      end
      S_WAIT: begin
        if (cnt_q > CW'(1)) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          state_d = S_IDLE;
          cnt_d   = '0;
          // Last WAIT edge is exactly when the register file's read data is valid.
          if (opc_q == OPC_READ) begin
            rd_data_d  = data_out;
            rd_valid_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      opc_q      <= OPC_NOP;
      cnt_q      <= '0;
      op_q       <= REG_READ;
      addr_a_q   <= '0;
      addr_b_q   <= '0;
      addr_r_q   <= '0;
      data_in_q  <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      opc_q      <= opc_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      addr_a_q   <= addr_a_d;
      addr_b_q   <= addr_b_d;
      addr_r_q   <= addr_r_d;
      data_in_q  <= data_in_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      illegal_q  <= illegal_d;
    end
  end

  assign instr_ready = (state_q == S_IDLE) && !reset;
  assign busy        = (state_q != S_IDLE);
  assign op          = op_q;
  assign addr_a      = addr_a_q;
  assign addr_b      = addr_b_q;
  assign addr_r      = addr_r_q;
  assign data_in     = data_in_q;
  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
  assign illegal     = illegal_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: transaction-offset model checked every cycle,
// a small register-file stand-in driving data_out, and directed literal checks.
module tb_alu_sequencer;
  import constants_pkg::*;

  localparam int AB = 3;
  localparam int DB = 8;
  localparam int WB = 2;
  localparam int RL = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [15:0]   instr = '0;
  logic          instr_valid = 1'b0;
  logic          instr_ready;
  ALUOp          op;
  logic [AB-1:0] addr_a, addr_b, addr_r;
  logic [DB-1:0] data_in, data_out, rd_data;
  logic          rd_valid, illegal, busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_sequencer #(.ADDR_BITS(AB), .DATA_BITS(DB), .WB_CYCLES(WB), .READ_LATENCY(RL)) dut (
    .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .op(op), .addr_a(addr_a), .addr_b(addr_b),
    .addr_r(addr_r), .data_in(data_in), .data_out(data_out), .rd_data(rd_data),
    .rd_valid(rd_valid), .illegal(illegal), .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Register-file stand-in: data_out shows rf[addr] RL edges after the read sample.
  logic [DB-1:0] rf [2**AB];
  logic [DB-1:0] rpipe [RL];
  initial begin
    for (int i = 0; i < 2**AB; i++) rf[i] = '0;
    for (int i = 0; i < RL; i++) rpipe[i] = '0;
  end
  always @(posedge clk) begin
    if (op == REG_WRITE) rf[addr_a] <= data_in;
    rpipe[0] <= rf[addr_a];
    for (int i = 1; i < RL; i++) rpipe[i] <= rpipe[i-1];
  end
  assign data_out = rpipe[RL-1];

  // Model: an accepted word occupies a fixed number of busy cycles; t counts them.
  bit            m_on = 1'b0;
  bit            m_act;
  int            m_t;
  logic [15:0]   m_w;
  logic [AB-1:0] m_ar;
  logic [DB-1:0] m_rd;
  bit            m_rv, m_ill;

  function automatic int busy_len(input logic [3:0] o);
    if (o == 4'h2 || o == 4'h3) return 1 + WB;
    if (o == 4'h4) return 1 + RL;
    return 1;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_on = 1'b1; m_act = 1'b0; m_t = 0; m_w = '0;
      m_ar = '0; m_rd = '0; m_rv = 1'b0; m_ill = 1'b0;
    end else begin
      m_rv = 1'b0;
      m_ill = 1'b0;
      if (m_act) begin
        m_t++;
        if (m_t == busy_len(m_w[15:12])) begin
          m_act = 1'b0;
          if (m_w[15:12] == 4'h4) begin
            m_rv = 1'b1;
            m_rd = data_out;
          end
        end
      end else if (instr_valid) begin
        m_act = 1'b1;
        m_t = 0;
        m_w = instr;
        if (instr[15:12] == 4'h2 || instr[15:12] == 4'h3) m_ar = instr[8 +: AB];
        if (instr[15:12] >= 4'h5) m_ill = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    logic [3:0]    o;
    bit            iss;
    ALUOp          e_op;
    logic [AB-1:0] e_a, e_b;
    logic [DB-1:0] e_d;
    if (m_on) begin
      o = m_w[15:12];
      iss = m_act && (m_t == 0);
      e_op = REG_READ; e_a = '0; e_b = '0; e_d = '0;
      if (iss) begin
        case (o)
          4'h1: begin e_op = REG_WRITE; e_a = m_w[8 +: AB]; e_d = m_w[DB-1:0]; end
          4'h2: begin e_op = ADD; e_a = m_w[4 +: AB]; e_b = m_w[0 +: AB]; end
          4'h3: begin e_op = SUB; e_a = m_w[4 +: AB]; e_b = m_w[0 +: AB]; end
          4'h4: e_a = m_w[8 +: AB];
          default: ;
        endcase
      end
      chk("m_op", 32'(op), 32'(e_op));
      chk("m_addr_a", 32'(addr_a), 32'(e_a));
      chk("m_addr_b", 32'(addr_b), 32'(e_b));
      chk("m_addr_r", 32'(addr_r), 32'(m_ar));
      chk("m_data_in", 32'(data_in), 32'(e_d));
      chk("m_rd_data", 32'(rd_data), 32'(m_rd));
      chk("m_rd_valid", 32'(rd_valid), 32'(m_rv));
      chk("m_illegal", 32'(illegal), 32'(m_ill));
      chk("m_busy", 32'(busy), 32'(m_act));
      chk("m_instr_ready", 32'(instr_ready), 32'(!m_act && !reset));
    end
  end

  // Waits for instr_ready, lets the accepting edge pass; waited = not-ready cycles seen.
  task automatic send(input logic [15:0] w, input bit hold, output int waited);
    waited = 0;
    instr = w;
    instr_valid = 1'b1;
    @(negedge clk);
    while (!instr_ready && waited < 40) begin
      waited++;
      @(negedge clk);
    end
    chk("ready_before_accept", 32'(instr_ready), 32'd1);
    @(posedge clk);
    #1;
    if (!hold) instr_valid = 1'b0;
  endtask

  initial begin
    int w, n;
    @(negedge clk);
    @(negedge clk);
    chk("ready_in_reset", 32'(instr_ready), 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_op", 32'(op), 32'(REG_READ));
    chk("rst_addr_a", 32'(addr_a), 32'd0);
    chk("rst_data_in", 32'(data_in), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(instr_ready), 32'd1);

    send(16'h135A, 1'b0, w);
    @(negedge clk);
    chk("loadi_op", 32'(op), 32'(REG_WRITE));
    chk("loadi_addr_a", 32'(addr_a), 32'd3);
    chk("loadi_data_in", 32'(data_in), 32'h5A);
    @(negedge clk);
    chk("loadi_op_once", 32'(op), 32'(REG_READ));
    chk("loadi_ready_back", 32'(instr_ready), 32'd1);

    send(16'h2231, 1'b1, w);
    instr = 16'h0000;
    @(negedge clk);
    chk("add_op", 32'(op), 32'(ADD));
    chk("add_addr_a", 32'(addr_a), 32'd3);
    chk("add_addr_b", 32'(addr_b), 32'd1);
    chk("add_addr_r", 32'(addr_r), 32'd2);
    send(16'h0000, 1'b0, w);
    chk("add_nop_spacing", 32'(w + 2), 32'd4);
    @(negedge clk);
    chk("add_addr_r_kept", 32'(addr_r), 32'd2);

    send(16'h3231, 1'b1, w);
    instr = 16'h0000;
    @(negedge clk);
    chk("sub_op", 32'(op), 32'(SUB));
    chk("sub_addr_r", 32'(addr_r), 32'd2);
    send(16'h0000, 1'b0, w);
    chk("sub_nop_spacing", 32'(w + 2), 32'd4);
    send(16'h2765, 1'b0, w);

    send(16'h4300, 1'b0, w);
    n = 0;
    do begin @(negedge clk); n++; end while (!rd_valid && n < 20);
    chk("read_rv_delay", 32'(n), 32'd4);
    chk("read_rd_data", 32'(rd_data), 32'h5A);
    @(negedge clk);
    chk("read_rv_once", 32'(rd_valid), 32'd0);

    send(16'h11A5, 1'b0, w);
    send(16'h4100, 1'b0, w);
    repeat (RL + 2) @(negedge clk);
    chk("read2_rd_data", 32'(rd_data), 32'hA5);

    send(16'hF123, 1'b0, w);
    @(negedge clk);
    chk("ill_pulse", 32'(illegal), 32'd1);
    chk("ill_op", 32'(op), 32'(REG_READ));
    chk("ill_addr_a", 32'(addr_a), 32'd0);
    @(negedge clk);
    chk("ill_once", 32'(illegal), 32'd0);
    chk("ill_ready", 32'(instr_ready), 32'd1);

    send(16'h4300, 1'b0, w);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("rstw_ready", 32'(instr_ready), 32'd1);
    chk("rstw_busy", 32'(busy), 32'd0);
    n = 0;
    repeat (6) begin
      if (rd_valid) n++;
      @(negedge clk);
    end
    chk("rstw_no_rv", 32'(n), 32'd0);
    chk("rstw_rd_data", 32'(rd_data), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
